// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: segment width,
// hex-to-segment table ({g,f,e,d,c,b,a}, active-high) and scan states.
package seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex digit to seven-segment pattern lookup.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0]       i_hex,
    output logic [SEG_W-1:0] o_seg
);

    assign o_seg = HEX_SEG[i_hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a double-buffered digit
// bank, dead-time between digits and leading-zero blanking; outputs registered.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DWELL  = 100,
    parameter int GAP    = 2,
    localparam int AW    = (DIGITS <= 2) ? 1 : $clog2(DIGITS),
    localparam int CW    = $clog2(((DWELL > GAP) ? DWELL : GAP) + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [3:0]        wr_data,
    input  logic              lz_blank,
    output logic [SEG_W-1:0]  seg,
    output logic [DIGITS-1:0] dig_sel,
    output logic              frame_done
);

    state_t              r_state;
    logic [AW-1:0]       r_idx;
    logic [CW-1:0]       r_cnt;
    logic [3:0]          r_shadow [DIGITS];
    logic [3:0]          r_active [DIGITS];
    logic [SEG_W-1:0]    r_seg;
    logic [DIGITS-1:0]   r_dig_sel;
    logic                r_frame_done;

    state_t              w_next_state;
    logic [AW-1:0]       w_next_idx;
    logic [CW-1:0]       w_next_cnt;
    logic                w_copy;
    logic                w_wrap;
    logic [3:0]          w_next_active [DIGITS];
    logic [DIGITS-1:0]   w_lz;
    logic                w_zero_above;
    logic [3:0]          w_digit;
    logic [SEG_W-1:0]    w_seg;
    logic                w_blank;

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_cnt   = r_cnt;
        w_copy       = 1'b0;
        w_wrap       = 1'b0;
        case (r_state)
            OFF: begin
                if (enable) begin
                    w_next_state = SHOW;
                    w_next_idx   = '0;
                    w_next_cnt   = '0;
                    w_copy       = 1'b1;
                end
            end
            SHOW, BLANK: begin
                if (!enable) begin
                    w_next_state = OFF;
                    w_next_idx   = '0;
                    w_next_cnt   = '0;
                end else if ((r_state == SHOW && r_cnt != CW'(DWELL - 1)) ||
                             (r_state == BLANK && r_cnt != CW'(GAP - 1))) begin
                    w_next_cnt = r_cnt + CW'(1);
                end else begin
                    w_next_cnt = '0;
                    if (r_state == SHOW && GAP > 0) begin
                        w_next_state = BLANK;
                    end else begin
                        // Advancing past the last digit starts a new frame.
                        w_next_state = SHOW;
                        if (r_idx == AW'(DIGITS - 1)) begin
                            w_next_idx = '0;
                            w_copy     = 1'b1;
                            w_wrap     = 1'b1;
                        end else begin
                            w_next_idx = r_idx + AW'(1);
                        end
                    end
                end
            end
            default: begin
                w_next_state = OFF;
                w_next_idx   = '0;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Outputs are computed from the post-edge bank so a frame copy and its
    // first digit appear on the same edge.
    always_comb begin
        w_zero_above = 1'b1;
        w_lz         = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_next_active[i] = w_copy ? r_shadow[i] : r_active[i];
        end
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above && (w_next_active[i] == 4'h0);
            w_lz[i]      = w_zero_above;
        end
    end

    assign w_digit = w_next_active[w_next_idx];
    assign w_blank = lz_blank && w_lz[w_next_idx];

    hex_to_seg u_hex_to_seg (
        .i_hex (w_digit),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= OFF;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_seg        <= '0;
            r_dig_sel    <= '0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                r_shadow[i] <= 4'h0;
                r_active[i] <= 4'h0;
            end
        end else begin
            r_state      <= w_next_state;
            r_idx        <= w_next_idx;
            r_cnt        <= w_next_cnt;
            r_frame_done <= w_wrap;
            for (int i = 0; i < DIGITS; i++) begin
                r_active[i] <= w_next_active[i];
            end
            if (wr_en && (int'(wr_addr) < DIGITS)) begin
                r_shadow[wr_addr] <= wr_data;
            end
            if (w_next_state == SHOW) begin
                r_seg     <= w_blank ? '0 : w_seg;
                r_dig_sel <= DIGITS'(1) << w_next_idx;
            end else begin
                r_seg     <= '0;
                r_dig_sel <= '0;
            end
        end
    end

    assign seg        = r_seg;
    assign dig_sel    = r_dig_sel;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a frame-time model (position within frame, banks
// snapshotted at frame start) drives expectations; a second GAP=0 instance.
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DWELL  = 4;
    localparam int GAP    = 1;
    localparam int PER    = DWELL + GAP;
    localparam int FRAME  = DIGITS * PER;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       lz_blank = 1'b0;
    logic [6:0] seg;
    logic [3:0] dig_sel;
    logic       frame_done;

    logic       enable2 = 1'b0;
    logic       wr_en2 = 1'b0;
    logic [1:0] wr_addr2 = '0;
    logic [3:0] wr_data2 = '0;
    logic       lz_blank2 = 1'b0;
    logic [6:0] seg2;
    logic [3:0] dig_sel2;
    logic       frame_done2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit         m_on = 0;
    int         m_t = 0;
    logic [3:0] m_sh  [4];
    logic [3:0] m_act [4];
    logic [6:0] e_seg;
    logic [3:0] e_dig;
    logic       e_fd;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .lz_blank(lz_blank),
        .seg(seg), .dig_sel(dig_sel), .frame_done(frame_done)
    );

    seg_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .GAP(0)) dut_gap0 (
        .clk(clk), .rst_n(rst_n), .enable(enable2), .wr_en(wr_en2),
        .wr_addr(wr_addr2), .wr_data(wr_data2), .lz_blank(lz_blank2),
        .seg(seg2), .dig_sel(dig_sel2), .frame_done(frame_done2)
    );

    function automatic logic [6:0] hexseg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic model_reset();
        m_on = 0;
        m_t  = 0;
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = 4'h0;
            m_act[i] = 4'h0;
        end
        e_seg = '0;
        e_dig = '0;
        e_fd  = 1'b0;
    endtask

    // Advance one clock, update the model with the inputs seen at that edge,
    // then settle to 1 time unit after the edge.
    task automatic tick();
        int pos, d;
        bit showing, blank;
        @(posedge clk);
        if (enable) begin
            if (!m_on) begin
                m_on = 1;
                m_t  = 0;
                for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
            end else begin
                m_t++;
                if (m_t % FRAME == 0)
                    for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
            end
        end else begin
            m_on = 0;
        end
        if (wr_en) m_sh[wr_addr] = wr_data;
        e_seg = '0;
        e_dig = '0;
        e_fd  = 1'b0;
        if (m_on) begin
            pos     = m_t % FRAME;
            d       = pos / PER;
            showing = (pos % PER) < DWELL;
            blank   = lz_blank && d >= 1;
            for (int j = 1; j < 4; j++)
                if (j >= d && m_act[j] != 4'h0) blank = 0;
            e_fd = (m_t > 0) && (pos == 0);
            if (showing) begin
                e_dig = 4'(1 << d);
                e_seg = blank ? 7'h00 : hexseg(m_act[d]);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (seg !== 7'h00 || dig_sel !== 4'h0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: seg=%h dig=%b fd=%b, required 00/0000/0", seg, dig_sel, frame_done);
        end
        model_reset();
        #4;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int fd_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i); wr_data = 4'(4 - i);
            tick();
            n_checks++;
            if (seg !== 7'h00 || dig_sel !== 4'h0) begin
                n_fail++;
                $display("FAIL off_idle: seg=%h dig=%b, required 00/0000", seg, dig_sel);
            end
        end
        wr_en = 1'b0;
        enable = 1'b1;
        tick();
        n_checks++;
        if (seg !== 7'h66 || dig_sel !== 4'b0001 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL first_show: seg=%h dig=%b fd=%b, required 66/0001/0", seg, dig_sel, frame_done);
        end
        for (int k = 0; k < 60; k++) begin
            tick();
            if (frame_done === 1'b1) fd_cnt++;
            n_checks++;
            if (seg !== e_seg || dig_sel !== e_dig || frame_done !== e_fd) begin
                n_fail++;
                $display("FAIL basic_scan t=%0d: seg=%h dig=%b fd=%b, required %h/%b/%b", m_t, seg, dig_sel, frame_done, e_seg, e_dig, e_fd);
            end
        end
        n_checks++;
        if (fd_cnt != 3) begin
            n_fail++;
            $display("FAIL frame_done_count: got %0d, required 3", fd_cnt);
        end
    endtask

    task automatic test_midframe_write();
        tick();
        tick();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h8;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (seg !== 7'h66 || dig_sel !== 4'b0001) begin
            n_fail++;
            $display("FAIL midframe_old: seg=%h dig=%b, required 66/0001", seg, dig_sel);
        end
        for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != 0; k++) begin
            tick();
            n_checks++;
            if (seg !== e_seg || dig_sel !== e_dig || frame_done !== e_fd) begin
                n_fail++;
                $display("FAIL midframe_scan t=%0d: seg=%h dig=%b fd=%b, required %h/%b/%b", m_t, seg, dig_sel, frame_done, e_seg, e_dig, e_fd);
            end
        end
        n_checks++;
        if (seg !== 7'h7F || dig_sel !== 4'b0001 || frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_new: seg=%h dig=%b fd=%b, required 7F/0001/1", seg, dig_sel, frame_done);
        end
    endtask

    task automatic test_wrap_write();
        for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != FRAME - 1; k++) tick();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h9;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (seg !== 7'h7F || frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_write_old: seg=%h fd=%b, required 7F/1", seg, frame_done);
        end
        for (int k = 0; k < FRAME - 1; k++) begin
            tick();
            n_checks++;
            if (seg !== e_seg || dig_sel !== e_dig || frame_done !== e_fd) begin
                n_fail++;
                $display("FAIL wrap_scan t=%0d: seg=%h dig=%b fd=%b, required %h/%b/%b", m_t, seg, dig_sel, frame_done, e_seg, e_dig, e_fd);
            end
        end
        tick();
        n_checks++;
        if (seg !== 7'h6F || dig_sel !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_write_new: seg=%h dig=%b, required 6F/0001", seg, dig_sel);
        end
    endtask

    task automatic test_lz_blank();
        logic [6:0] lz_exp [4];
        lz_exp = '{7'h3F, 7'h6D, 7'h00, 7'h00};
        lz_blank = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i); wr_data = (i == 1) ? 4'h5 : 4'h0;
            tick();
        end
        wr_en = 1'b0;
        for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != FRAME - 1; k++) tick();
        for (int k = 0; k < FRAME; k++) begin
            tick();
            n_checks++;
            if (seg !== e_seg || dig_sel !== e_dig) begin
                n_fail++;
                $display("FAIL lz_scan t=%0d: seg=%h dig=%b, required %h/%b", m_t, seg, dig_sel, e_seg, e_dig);
            end
            if (k % PER == 0) begin
                n_checks++;
                if (seg !== lz_exp[k / PER] || dig_sel !== 4'(1 << (k / PER))) begin
                    n_fail++;
                    $display("FAIL lz_digit%0d: seg=%h dig=%b, required %h/%b", k / PER, seg, dig_sel, lz_exp[k / PER], 4'(1 << (k / PER)));
                end
            end
        end
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h0;
        tick();
        wr_en = 1'b0;
        for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != FRAME - 1; k++) tick();
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (k % PER < DWELL) begin
                n_checks++;
                if (seg !== ((k < PER) ? 7'h3F : 7'h00) || dig_sel !== 4'(1 << (k / PER))) begin
                    n_fail++;
                    $display("FAIL lz_all_zero k=%0d: seg=%h dig=%b", k, seg, dig_sel);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != 2 * PER - 1; k++) tick();
        n_checks++;
        if (seg !== 7'h00 || dig_sel !== 4'h0) begin
            n_fail++;
            $display("FAIL blank_after_d1: seg=%h dig=%b, required 00/0000", seg, dig_sel);
        end
        enable = 1'b0;
        tick();
        n_checks++;
        if (seg !== 7'h00 || dig_sel !== 4'h0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop: seg=%h dig=%b fd=%b, required 00/0000/0", seg, dig_sel, frame_done);
        end
        tick();
        tick();
        enable = 1'b1;
        tick();
        n_checks++;
        if (seg !== e_seg || dig_sel !== 4'b0001 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reenable: seg=%h dig=%b fd=%b, required %h/0001/0", seg, dig_sel, frame_done, e_seg);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 2'($urandom);
            wr_data = 4'($urandom);
            if ($urandom_range(0, 7) == 0) lz_blank = ~lz_blank;
            enable  = ($urandom_range(0, 59) != 0);
            tick();
            n_checks++;
            if (seg !== e_seg || dig_sel !== e_dig || frame_done !== e_fd) begin
                n_fail++;
                $display("FAIL random t=%0d: seg=%h dig=%b fd=%b, required %h/%b/%b", m_t, seg, dig_sel, frame_done, e_seg, e_dig, e_fd);
            end
        end
        wr_en = 1'b0;
        enable = 1'b1;
        lz_blank = 1'b0;
    endtask

    task automatic test_async_reset();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'hA;
        tick();
        wr_en = 1'b0;
        for (int k = 0; k < 3 * FRAME && !(m_t % FRAME == 2 && m_t >= FRAME); k++) tick();
        n_checks++;
        if (seg !== 7'h77 || dig_sel !== 4'b0001) begin
            n_fail++;
            $display("FAIL pre_reset_show: seg=%h dig=%b, required 77/0001", seg, dig_sel);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (seg !== 7'h00 || dig_sel !== 4'h0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: seg=%h dig=%b fd=%b, required 00/0000/0", seg, dig_sel, frame_done);
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (seg !== 7'h3F || dig_sel !== 4'b0001) begin
            n_fail++;
            $display("FAIL after_reset_show: seg=%h dig=%b, required 3F/0001", seg, dig_sel);
        end
    endtask

    task automatic test_gap0();
        logic [3:0] v [4];
        for (int i = 0; i < 4; i++) begin
            v[i] = 4'($urandom);
            wr_en2 = 1'b1; wr_addr2 = 2'(i); wr_data2 = v[i];
            tick();
        end
        wr_en2 = 1'b0;
        enable2 = 1'b1;
        for (int k = 0; k < DIGITS * DWELL; k++) begin
            tick();
            n_checks++;
            if (seg2 !== hexseg(v[k / DWELL]) || dig_sel2 !== 4'(1 << (k / DWELL)) || frame_done2 !== 1'b0) begin
                n_fail++;
                $display("FAIL gap0_scan k=%0d: seg=%h dig=%b fd=%b, required %h/%b/0", k, seg2, dig_sel2, frame_done2, hexseg(v[k / DWELL]), 4'(1 << (k / DWELL)));
            end
        end
        tick();
        n_checks++;
        if (seg2 !== hexseg(v[0]) || dig_sel2 !== 4'b0001 || frame_done2 !== 1'b1) begin
            n_fail++;
            $display("FAIL gap0_wrap: seg=%h dig=%b fd=%b, required %h/0001/1", seg2, dig_sel2, frame_done2, hexseg(v[0]));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_midframe_write();
        test_wrap_write();
        test_lz_blank();
        test_enable_drop();
        test_random();
        test_async_reset();
        test_gap0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller that shares one seven-segment decoder and segment bus across DIGITS common-cathode digits. It sits between the counting/control logic, which writes hex digit values, and the chip outputs (segments plus digit selects). It double-buffers digit values so that a frame never tears, inserts dead-time between digits to stop ghosting, and supports leading-zero blanking.

Parameters:
DIGITS, 4, number of multiplexed digits; must be 2..8. Digit index 0 is the least significant digit.
DWELL, 100, clock cycles each digit is driven; must be >= 1.
GAP, 2, dead-time cycles between digits with all outputs off; 0 is legal.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  scanning runs while high; low forces the OFF state.
wr_en  input  1  write strobe into the shadow digit bank.
wr_addr  input  AW  digit index, where AW = max(1, clog2(DIGITS)).
wr_data  input  4  hex value, 0x0..0xF.
lz_blank  input  1  enables leading-zero blanking.
seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered.
dig_sel  output  DIGITS  one-hot digit enable, active-high, registered.
frame_done  output  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (asynchronous on rst_n low):
  - State = OFF; idx = 0; dwell/gap counter = 0.
  - Shadow and active banks are all 0.
  - seg = 0, dig_sel = 0, frame_done = 0.
- States: OFF, SHOW, BLANK. All outputs are registered and change on the same edge as the state.
- OFF:
  - seg = 0, dig_sel = 0.
  - When enable is sampled at 1: next edge enters SHOW with idx = 0, and active bank <= shadow bank (frame copy).
- SHOW:
  - seg = decode(active[idx]); dig_sel = 1 << idx.
  - Held for exactly DWELL cycles.
  - Then BLANK if GAP > 0, otherwise the next digit's SHOW directly.
- BLANK:
  - seg = 0, dig_sel = 0.
  - Held for exactly GAP cycles, then SHOW of idx+1.
- Wrap:
  - When leaving the last period of idx = DIGITS-1, the next SHOW uses idx = 0, the frame copy happens, and frame_done = 1 for that one cycle.
  - Frame length = DIGITS*(DWELL+GAP) cycles.
- enable low: sampled in SHOW or BLANK, the next edge goes to OFF with idx = 0 and outputs 0. No frame_done pulse. Counters reset.
- Writes:
  - wr_en = 1 updates shadow[wr_addr] at the edge, in any state including OFF.
  - wr_addr >= DIGITS is ignored.
  - A write and a frame copy on the same edge: the active bank receives the pre-write shadow value; the new value shows from the next frame.
- Decode (hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
- Leading-zero blanking:
  - When lz_blank = 1, digit i (i >= 1) shows seg = 0 if active[j] == 0 for all j >= i.
  - Digit 0 is never blanked.
  - dig_sel still asserts during a blanked digit, so timing is unchanged.
  - Evaluated on the active bank, so it is stable within a frame.
- Counter width = clog2(max(DWELL, GAP) + 1); no wrap other than the defined terminal counts.

Decomposition:
- Package seg_pkg:
  - SEG_W = 7.
  - The 16-entry hex-to-segment constant table.
  - State enum {OFF, SHOW, BLANK} (2 bits).
- One sub-module: hex_to_seg (4-bit in, 7-bit out, combinational lookup into seg_pkg), instantiated once on the muxed active digit.

Test Plan:
All scenarios use DIGITS=4, DWELL=4, GAP=1.
1. Reset, write shadow = {3:0x1, 2:0x2, 1:0x3, 0:0x4}, raise enable -> one cycle later seg=66 dig_sel=0001 for 4 cycles, then 0/0000 for 1 cycle, then seg=4F dig_sel=0010; frame_done pulses every 20 cycles, on the cycle idx=0 SHOW begins.
2. Mid-frame write of digit 0 to 0x8 -> current frame still shows 66 on dig_sel=0001; the next frame shows 7F.
3. Write coincident with the wrap edge -> old value for that frame, new value one frame later.
4. lz_blank=1, shadow = {0,0,5,0} -> digits 3 and 2 seg=00 with dig_sel asserted; digit 1 = 6D; digit 0 = 3F. Shadow all-zero -> only digit 0 shows 3F.
5. Drop enable during BLANK after digit 1 -> next edge seg=0, dig_sel=0, no frame_done. Re-enable -> restarts at idx 0.
6. Assert rst_n=0 asynchronously mid-SHOW -> outputs 0 immediately without a clock edge; the banks clear, so after re-enable digit 0 shows 3F. Also: GAP=0 build -> SHOW to SHOW back-to-back with no zero cycle.
